sdr_cmd_decoder: RTL

Device-side SDRAM command decoder and protocol checker, sitting on the SDRAM pin bus opposite the controller under test (same `top.duv` command pins the whitebox interface samples). It registers each command on `sdram_clk`, decodes it into a typed command stream, and tracks per-bank open/closed state with tRCD/tRP/tRFC/tMRD counters. It also follows the power-up init sequence and flags protocol violations with a coded pulse and a saturating counter.

---
 rtl/sdr_cmd_decoder_pkg.sv | 64 ++++++
 rtl/sdr_cmd_decoder_if.sv | 51 +++++
 rtl/sdr_cmd_decoder_bank_tracker.sv | 88 ++++++++
 rtl/sdr_cmd_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sdr_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_cmd_pkg
//  Description : Shared types and default timing for the SDRAM command
//                decoder / protocol checker.
//                  cmd_t      - decoded command stream value
//                  viol_t     - violation code (lower value = higher priority)
//                  bank_st_t  - per-bank lifecycle state
//                  init_st_t  - power-up init sequence tracker state
//  Revision    : 1.0 - initial release
// ============================================================================
package sdr_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_MRS = 3'd6,
        CMD_BST = 3'd7
    } cmd_t;

    typedef enum logic [2:0] {
        V_NONE      = 3'd0,
        V_TRFC_BUSY = 3'd1,
        V_ACT_OPEN  = 3'd2,
        V_TRP       = 3'd3,
        V_TRCD      = 3'd4,
        V_RW_IDLE   = 3'd5,
        V_REF_OPEN  = 3'd6,
        V_MRS_OPEN  = 3'd7
    } viol_t;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_st_t;

    typedef enum logic [2:0] {
        INIT_WAIT_PRE  = 3'd0,
        INIT_WAIT_REF1 = 3'd1,
        INIT_WAIT_REF2 = 3'd2,
        INIT_WAIT_MRS  = 3'd3,
        INIT_DONE      = 3'd4
    } init_st_t;

    localparam int C_TRCD      = 3;
    localparam int C_TRP       = 3;
    localparam int C_TRFC      = 7;
    localparam int C_TMRD      = 2;
    localparam int C_AW        = 13;
    localparam int C_NUM_BANKS = 4;
    localparam int C_A10       = 10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_cmd_decoder_if
//  Description : SDRAM pin bus plus the decoded command / checker outputs.
//                master : drives the command pins (controller side),
//                         observes the decoded stream.
//                slave  : samples the command pins (decoder side),
//                         drives the decoded stream.
//  Ports       : sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
//                sdr_ba[1:0], sdr_addr[AW-1:0]          (pins)
//                cmd_valid, cmd_code, cmd_ba, cmd_addr, bank_open[3:0],
//                init_done, viol, viol_code, viol_cnt[7:0] (decoded)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdr_cmd_decoder_if #(
    parameter int AW = 13
);
    import sdr_cmd_pkg::*;

    logic          sdr_cke;
    logic          sdr_cs_n;
    logic          sdr_ras_n;
    logic          sdr_cas_n;
    logic          sdr_we_n;
    logic [1:0]    sdr_ba;
    logic [AW-1:0] sdr_addr;

    logic          cmd_valid;
    cmd_t          cmd_code;
    logic [1:0]    cmd_ba;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    bank_open;
    logic          init_done;
    logic          viol;
    viol_t         viol_code;
    logic [7:0]    viol_cnt;

    modport master (
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr,
        input  cmd_valid, cmd_code, cmd_ba, cmd_addr, bank_open, init_done,
               viol, viol_code, viol_cnt
    );

    modport slave (
        input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr,
        output cmd_valid, cmd_code, cmd_ba, cmd_addr, bank_open, init_done,
               viol, viol_code, viol_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sdr_cmd_decoder_bank_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_bank_tracker
//  Description : One SDRAM bank's open/closed FSM with its tRCD/tRP counter.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_act           - legal ACT to this bank
//                i_pre           - legal PRE / PRE-all covering this bank
//                i_auto_pre      - legal RD/WR with auto-precharge to this bank
//                o_state         - registered bank state
//                o_eff_state     - state as seen by a command this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module sdr_bank_tracker
    import sdr_cmd_pkg::*;
#(
    parameter int TRCD = C_TRCD,
    parameter int TRP  = C_TRP
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_act,
    input  logic     i_pre,
    input  logic     i_auto_pre,
    output bank_st_t o_state,
    output bank_st_t o_eff_state
);

    localparam int CW = (max2(TRCD, TRP) < 2) ? 1 : $clog2(max2(TRCD, TRP) + 1);

    bank_st_t      st_q, st_d, eff_st;
    logic [CW-1:0] cnt_q, cnt_d;

    // A timed state whose counter has reached zero is finished this cycle:
    // the command sampled on this edge already sees the settled state.
    // That is what makes an ACT at edge N followed by RD at edge N+TRCD legal.
    always_comb begin
        eff_st = st_q;
        if (cnt_q == '0) begin
            if (st_q == BANK_ACTIVATING) begin
                eff_st = BANK_ACTIVE;
            end else if (st_q == BANK_PRECHARGING) begin
                eff_st = BANK_IDLE;
            end
        end
    end

    always_comb begin
        st_d  = eff_st;
        cnt_d = (cnt_q != '0) ? (cnt_q - 1'b1) : cnt_q;
        case (eff_st)
            BANK_IDLE: begin
                if (i_act) begin
                    st_d  = BANK_ACTIVATING;
                    cnt_d = CW'(TRCD - 1);
                end
            end
            BANK_ACTIVATING: begin
                if (i_pre) begin
                    st_d  = BANK_PRECHARGING;
                    cnt_d = CW'(TRP - 1);
                end
            end
            BANK_ACTIVE: begin
                if (i_pre || i_auto_pre) begin
                    st_d  = BANK_PRECHARGING;
                    cnt_d = CW'(TRP - 1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= BANK_IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_state     = st_q;
    assign o_eff_state = eff_st;

endmodule
`default_nettype wire

// File: rtl/sdr_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_cmd_decoder
//  Description : Device-side SDRAM command decoder and protocol checker.
//                Registers each pin command, reports it as a typed stream,
//                tracks per-bank state, tRFC/tMRD busy time and the power-up
//                init sequence, and flags protocol violations.
//  Ports       : sdram_clk    - sole clock
//                sdram_resetn - asynchronous active-low reset
//                bus          - sdr_cmd_decoder_if.slave (pins in,
//                               decoded stream / checker results out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdr_cmd_decoder
    import sdr_cmd_pkg::*;
#(
    parameter int TRCD = C_TRCD,
    parameter int TRP  = C_TRP,
    parameter int TRFC = C_TRFC,
    parameter int TMRD = C_TMRD,
    parameter int AW   = C_AW
) (
    input  logic               sdram_clk,
    input  logic               sdram_resetn,
    sdr_cmd_decoder_if.slave   bus
);

    localparam int BW = (max2(TRFC, TMRD) < 2) ? 1 : $clog2(max2(TRFC, TMRD) + 1);

    cmd_t      cmd;
    viol_t     vcode;
    logic      cmd_ok;
    logic      a10;
    logic      any_open;
    bank_st_t  bank_st  [C_NUM_BANKS];
    bank_st_t  bank_eff [C_NUM_BANKS];
    bank_st_t  tgt_st;
    logic [C_NUM_BANKS-1:0] act_stb, pre_stb, apre_stb;

    logic          cmd_valid_q, cmd_valid_d;
    cmd_t          cmd_code_q,  cmd_code_d;
    logic [1:0]    cmd_ba_q,    cmd_ba_d;
    logic [AW-1:0] cmd_addr_q,  cmd_addr_d;
    logic          viol_q,      viol_d;
    viol_t         viol_code_q, viol_code_d;
    logic [7:0]    viol_cnt_q,  viol_cnt_d;
    logic [BW-1:0] busy_q,      busy_d;
    init_st_t      init_q,      init_d;
    logic          init_done_q, init_done_d;

    assign a10 = bus.sdr_addr[C_A10];

    // ---------------- pin decode ----------------
    always_comb begin
        cmd = CMD_NOP;
        if (bus.sdr_cke && !bus.sdr_cs_n) begin
            case ({bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                3'b110:  cmd = CMD_BST;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // ---------------- violation priority ----------------
    always_comb begin
        any_open = 1'b0;
        for (int b = 0; b < C_NUM_BANKS; b++) begin
            if (bank_eff[b] != BANK_IDLE) begin
                any_open = 1'b1;
            end
        end
    end

    assign tgt_st = bank_eff[bus.sdr_ba];

    // Only one of codes 2..7 can apply to a given command, so the sole
    // priority decision is busy (code 1) over everything else.
    always_comb begin
        vcode = V_NONE;
        if (cmd != CMD_NOP) begin
            if (busy_q != '0) begin
                vcode = V_TRFC_BUSY;
            end else begin
                case (cmd)
                    CMD_ACT: begin
                        if (tgt_st == BANK_ACTIVATING || tgt_st == BANK_ACTIVE) begin
                            vcode = V_ACT_OPEN;
                        end else if (tgt_st == BANK_PRECHARGING) begin
                            vcode = V_TRP;
                        end
                    end
                    CMD_RD, CMD_WR: begin
                        if (tgt_st == BANK_ACTIVATING) begin
                            vcode = V_TRCD;
                        end else if (tgt_st != BANK_ACTIVE) begin
                            vcode = V_RW_IDLE;
                        end
                    end
                    CMD_REF: if (any_open) vcode = V_REF_OPEN;
                    CMD_MRS: if (any_open) vcode = V_MRS_OPEN;
                    default: begin
                    end
                endcase
            end
        end
    end

    // A violating command changes no tracked state.
    assign cmd_ok = (cmd != CMD_NOP) && (vcode == V_NONE);

    // ---------------- bank trackers ----------------
    for (genvar b = 0; b < C_NUM_BANKS; b++) begin : g_bank
        assign act_stb[b]  = cmd_ok && (cmd == CMD_ACT) && (bus.sdr_ba == 2'(b));
        assign pre_stb[b]  = cmd_ok && (cmd == CMD_PRE) && (a10 || (bus.sdr_ba == 2'(b)));
        assign apre_stb[b] = cmd_ok && (cmd == CMD_RD || cmd == CMD_WR) && a10
                             && (bus.sdr_ba == 2'(b));

        sdr_bank_tracker #(
            .TRCD (TRCD),
            .TRP  (TRP)
        ) u_bank (
            .clk         (sdram_clk),
            .rst_n       (sdram_resetn),
            .i_act       (act_stb[b]),
            .i_pre       (pre_stb[b]),
            .i_auto_pre  (apre_stb[b]),
            .o_state     (bank_st[b]),
            .o_eff_state (bank_eff[b])
        );

        assign bus.bank_open[b] = (bank_st[b] == BANK_ACTIVE);
    end

    // ---------------- busy counter, output stream, viol_cnt ----------------
    always_comb begin
        busy_d = (busy_q != '0) ? (busy_q - 1'b1) : busy_q;
        if (cmd_ok && cmd == CMD_REF) begin
            busy_d = BW'(TRFC - 1);
        end else if (cmd_ok && cmd == CMD_MRS) begin
            busy_d = BW'(TMRD - 1);
        end

        cmd_valid_d = (cmd != CMD_NOP);
        cmd_code_d  = cmd;
        cmd_ba_d    = (cmd != CMD_NOP) ? bus.sdr_ba   : '0;
        cmd_addr_d  = (cmd != CMD_NOP) ? bus.sdr_addr : '0;
        viol_d      = (vcode != V_NONE);
        viol_code_d = vcode;

        viol_cnt_d = viol_cnt_q;
        if (vcode != V_NONE && viol_cnt_q != 8'hFF) begin
            viol_cnt_d = viol_cnt_q + 8'd1;
        end
    end

    // ---------------- init sequence tracker ----------------
    always_comb begin
        init_d = init_q;
        if (cmd_ok) begin
            case (init_q)
                INIT_WAIT_PRE:  if (cmd == CMD_PRE && a10) init_d = INIT_WAIT_REF1;
                INIT_WAIT_REF1: if (cmd == CMD_REF)        init_d = INIT_WAIT_REF2;
                INIT_WAIT_REF2: if (cmd == CMD_REF)        init_d = INIT_WAIT_MRS;
                INIT_WAIT_MRS:  if (cmd == CMD_MRS)        init_d = INIT_DONE;
                default:                                   init_d = init_q;
            endcase
        end
        // Flag follows the tracker by one cycle, so it rises the cycle after
        // the completing MRS is reported.
        init_done_d = init_done_q || (init_q == INIT_DONE);
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NOP;
            cmd_ba_q    <= '0;
            cmd_addr_q  <= '0;
            viol_q      <= 1'b0;
            viol_code_q <= V_NONE;
            viol_cnt_q  <= '0;
            busy_q      <= '0;
            init_q      <= INIT_WAIT_PRE;
            init_done_q <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_addr_q  <= cmd_addr_d;
            viol_q      <= viol_d;
            viol_code_q <= viol_code_d;
            viol_cnt_q  <= viol_cnt_d;
            busy_q      <= busy_d;
            init_q      <= init_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_code  = cmd_code_q;
    assign bus.cmd_ba    = cmd_ba_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.viol      = viol_q;
    assign bus.viol_code = viol_code_q;
    assign bus.viol_cnt  = viol_cnt_q;
    assign bus.init_done = init_done_q;

endmodule
`default_nettype wire
